// File: rtl/bloco_controle.sv
// bloco_controle: control FSM sequencing the 16-bit operative block to evaluate one of four expressions into S
// Parameter DONE_HOLD: 0 = done is a one-cycle pulse, 1 = done stays high in IDLE until the next accepted start.
// Optional macro BLOCO_CONTROLE_BUSY_ERR_EN adds the sticky err output (start seen while busy).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, op[1:0]      request (sampled only in IDLE) and expression select (latched on acceptance)
//   busy, done          handshake: busy in every non-IDLE state, done on completion
//   LX, LH, LS          load enables for registers X, H, S
//   M0, M1, M2, H       mux selects and ALU subtract for the operative block
//   err (optional)      sticky flag for a start request arriving mid-sequence
module bloco_controle #(
  parameter int DONE_HOLD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] op,
  output logic       busy,
  output logic       done,
  output logic       LX,
  output logic       LH,
  output logic       LS,
  output logic [1:0] M0,
  output logic [1:0] M1,
  output logic [1:0] M2,
  output logic       H
`ifdef BLOCO_CONTROLE_BUSY_ERR_EN
  ,
  output logic       err
`endif
);
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    LOADX = 4'd1,
    HCALC = 4'd2,
    CLR   = 4'd3,
    ACC_A = 4'd4,
    ADD_B = 4'd5,
    SUB_B = 4'd6,
    ADD_C = 4'd7,
    ADD_X = 4'd8,
    SUB_H = 4'd9,
    DONE  = 4'd10
  } state_t;
  state_t      state_q, state_d;
  logic [1:0]  op_q;
  logic [9:0]  cw_q, cw_d;
  logic        busy_q, done_q, accept;
  assign accept = (state_q == IDLE) && start;
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = start ? (op[1] ? LOADX : CLR) : IDLE;
      LOADX:   state_d = (op_q == 2'b11) ? HCALC : CLR;
      HCALC:   state_d = CLR;
      CLR:     state_d = ACC_A;
      ACC_A:   state_d = (op_q == 2'b10) ? SUB_B : ADD_B;
      ADD_B:   state_d = (op_q == 2'b00) ? DONE : (op_q == 2'b01) ? ADD_C : SUB_H;
      SUB_B:   state_d = ADD_X;
      ADD_C:   state_d = DONE;
      ADD_X:   state_d = DONE;
      SUB_H:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Control word {LX, LH, LS, M0, M1, M2, H}, registered from the next state so the outputs are a pure
  // function of the state register while avoiding a decode glitch on the pins.
  always_comb begin
    cw_d = '0;
    case (state_d)
      LOADX:   cw_d = 10'b1_0_0_00_00_00_0;
      HCALC:   cw_d = 10'b0_1_0_11_00_00_0;
      CLR:     cw_d = 10'b0_0_1_01_00_01_1;
      ACC_A:   cw_d = 10'b0_0_1_01_00_10_0;
      ADD_B:   cw_d = 10'b0_0_1_10_00_10_0;
      SUB_B:   cw_d = 10'b0_0_1_10_00_10_1;
      ADD_C:   cw_d = 10'b0_0_1_11_00_10_0;
      ADD_X:   cw_d = 10'b0_0_1_00_01_10_0;
      SUB_H:   cw_d = 10'b0_0_1_00_11_10_1;
      default: cw_d = '0;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= 2'b00;
      cw_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) op_q <= op;
      cw_q    <= cw_d;
      busy_q  <= state_d != IDLE;
      // With DONE_HOLD the flag lingers through IDLE; leaving IDLE means a start was accepted.
      done_q  <= (state_d == DONE) || ((DONE_HOLD != 0) && done_q && (state_d == IDLE));
    end
  end
`ifdef BLOCO_CONTROLE_BUSY_ERR_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (accept) err_q <= 1'b0;
    else if (start && (state_q != IDLE) && (state_q != DONE)) err_q <= 1'b1;
  end
  assign err = err_q;
`endif
  assign {LX, LH, LS, M0, M1, M2, H} = cw_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_bloco_controle.sv
// tb_bloco_controle: directed bench with a behavioural operative block model for bloco_controle
module tb_bloco_controle;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [1:0]  op;
  logic [15:0] A, B, C, K;
  logic        busy0, done0, lx0, lh0, ls0, h0;
  logic [1:0]  m00, m10, m20;
  logic        busy1, done1, lx1, lh1, ls1, h1;
  logic [1:0]  m01, m11, m21;
  logic [9:0]  cw0, cw1;
  int          checks = 0;
  int          failures = 0;
`ifdef BLOCO_CONTROLE_BUSY_ERR_EN
  logic err0, err1;
`endif
  localparam logic [9:0] W_IDLE  = 10'b0000000000;
  localparam logic [9:0] W_LOADX = 10'b1000000000;
  localparam logic [9:0] W_HCALC = 10'b0101100000;
  localparam logic [9:0] W_CLR   = 10'b0010100011;
  localparam logic [9:0] W_ACC_A = 10'b0010100100;
  localparam logic [9:0] W_ADD_B = 10'b0011000100;
  localparam logic [9:0] W_SUB_B = 10'b0011000101;
  localparam logic [9:0] W_ADD_C = 10'b0011100100;
  localparam logic [9:0] W_ADD_X = 10'b0010001100;
  localparam logic [9:0] W_SUB_H = 10'b0010011101;
  always #5 clk = ~clk;
  bloco_controle #(.DONE_HOLD(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .busy(busy0), .done(done0),
    .LX(lx0), .LH(lh0), .LS(ls0), .M0(m00), .M1(m10), .M2(m20), .H(h0)
`ifdef BLOCO_CONTROLE_BUSY_ERR_EN
    , .err(err0)
`endif
  );
  bloco_controle #(.DONE_HOLD(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .busy(busy1), .done(done1),
    .LX(lx1), .LH(lh1), .LS(ls1), .M0(m01), .M1(m11), .M2(m21), .H(h1)
`ifdef BLOCO_CONTROLE_BUSY_ERR_EN
    , .err(err1)
`endif
  );
  assign cw0 = {lx0, lh0, ls0, m00, m10, m20, h0};
  assign cw1 = {lx1, lh1, ls1, m01, m11, m21, h1};
  logic [15:0] X, S, Hr, m0o, in0, in1, alu;
  always_comb begin
    m0o = (m00 == 2'd0) ? K : (m00 == 2'd1) ? A : (m00 == 2'd2) ? B : C;
    in1 = (m10 == 2'd0) ? m0o : (m10 == 2'd1) ? X : (m10 == 2'd2) ? S : Hr;
    in0 = (m20 == 2'd0) ? X : (m20 == 2'd1) ? m0o : (m20 == 2'd2) ? S : Hr;
    alu = h0 ? in0 - in1 : in0 + in1;
  end
  always @(posedge clk) begin
    if (lx0) X <= m0o;
    if (lh0) Hr <= alu;
    if (ls0) S <= alu;
  end
  task automatic ck(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk(input string tag, input logic [9:0] w, input logic b, input logic d, input logic d1);
    ck({tag, ".cw"}, {6'd0, cw0}, {6'd0, w});
    ck({tag, ".busy"}, {15'd0, busy0}, {15'd0, b});
    ck({tag, ".done"}, {15'd0, done0}, {15'd0, d});
    ck({tag, ".cw_hold"}, {6'd0, cw1}, {6'd0, w});
    ck({tag, ".busy_hold"}, {15'd0, busy1}, {15'd0, b});
    ck({tag, ".done_hold"}, {15'd0, done1}, {15'd0, d1});
  endtask
  task automatic tk;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; start = 1'b0; op = 2'b00;
    A = '0; B = '0; C = '0; K = '0;
    #2;
    chk("reset", W_IDLE, 0, 0, 0);
`ifdef BLOCO_CONTROLE_BUSY_ERR_EN
    ck("reset.err", {15'd0, err0}, 16'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tk;
    chk("idle", W_IDLE, 0, 0, 0);
    A = 16'd5; B = 16'd3; op = 2'b00; start = 1'b1;
    tk; start = 1'b0;
    chk("op0.clr", W_CLR, 1, 0, 0); tk;
    chk("op0.acca", W_ACC_A, 1, 0, 0); tk;
    chk("op0.addb", W_ADD_B, 1, 0, 0); tk;
    chk("op0.done", W_IDLE, 1, 1, 1);
    ck("op0.S", S, 16'd8); tk;
    chk("op0.idle", W_IDLE, 0, 0, 1); tk;
    chk("op0.idle2", W_IDLE, 0, 0, 1);
    C = 16'd2; op = 2'b01; start = 1'b1;
    tk; start = 1'b0; op = 2'b00;
    chk("op1.clr", W_CLR, 1, 0, 0); tk;
    chk("op1.acca", W_ACC_A, 1, 0, 0); tk;
    chk("op1.addb", W_ADD_B, 1, 0, 0); tk;
    chk("op1.addc", W_ADD_C, 1, 0, 0); tk;
    chk("op1.done", W_IDLE, 1, 1, 1);
    ck("op1.S", S, 16'd10); tk;
    chk("op1.idle", W_IDLE, 0, 0, 1);
    A = 16'hFFFF; B = 16'd1; C = 16'd1; op = 2'b01; start = 1'b1;
    tk; start = 1'b0;
    chk("wrap.clr", W_CLR, 1, 0, 0); tk;
    tk; tk;
    chk("wrap.addc", W_ADD_C, 1, 0, 0); tk;
    chk("wrap.done", W_IDLE, 1, 1, 1);
    ck("wrap.S", S, 16'h0001); tk;
    A = 16'd5; B = 16'd3; K = 16'd1; op = 2'b10; start = 1'b1;
    tk; start = 1'b0;
    chk("op2.loadx", W_LOADX, 1, 0, 0); tk;
    chk("op2.clr", W_CLR, 1, 0, 0); tk;
    chk("op2.acca", W_ACC_A, 1, 0, 0); tk;
    chk("op2.subb", W_SUB_B, 1, 0, 0); tk;
    chk("op2.addx", W_ADD_X, 1, 0, 0); tk;
    chk("op2.done", W_IDLE, 1, 1, 1);
    ck("op2.S", S, 16'd3); tk;
    A = 16'd0; B = 16'd1; K = 16'd0; op = 2'b10; start = 1'b1;
    tk; start = 1'b0;
    tk; tk; tk; tk;
    chk("neg.addx", W_ADD_X, 1, 0, 0); tk;
    chk("neg.done", W_IDLE, 1, 1, 1);
    ck("neg.S", S, 16'hFFFF); tk;
    A = 16'd5; B = 16'd3; C = 16'd2; K = 16'd1; op = 2'b11; start = 1'b1;
    tk; start = 1'b0;
    chk("op3.loadx", W_LOADX, 1, 0, 0);
    start = 1'b1; op = 2'b00;
    tk; start = 1'b0;
    chk("op3.hcalc", W_HCALC, 1, 0, 0); tk;
    chk("op3.clr", W_CLR, 1, 0, 0); tk;
    chk("op3.acca", W_ACC_A, 1, 0, 0); tk;
    chk("op3.addb", W_ADD_B, 1, 0, 0); tk;
    chk("op3.subh", W_SUB_H, 1, 0, 0); tk;
    chk("op3.done", W_IDLE, 1, 1, 1);
    ck("op3.S", S, 16'd5);
    ck("op3.Hreg", Hr, 16'd3);
`ifdef BLOCO_CONTROLE_BUSY_ERR_EN
    ck("op3.err", {15'd0, err0}, 16'd1);
    ck("op3.err_hold", {15'd0, err1}, 16'd1);
`endif
    tk;
    chk("op3.idle", W_IDLE, 0, 0, 1);
    op = 2'b11; start = 1'b1;
    tk; start = 1'b0;
    chk("rst.loadx", W_LOADX, 1, 0, 0);
`ifdef BLOCO_CONTROLE_BUSY_ERR_EN
    ck("rst.err_clr", {15'd0, err0}, 16'd0);
`endif
    tk; tk; tk; tk;
    chk("rst.addb", W_ADD_B, 1, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("rst.mid", W_IDLE, 0, 0, 0);
    ck("rst.S", S, 16'd5);
    tk;
    ck("rst.S_kept", S, 16'd5);
    chk("rst.held", W_IDLE, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    op = 2'b00; start = 1'b1;
    tk;
    chk("b2b.clr", W_CLR, 1, 0, 0); tk;
    chk("b2b.acca", W_ACC_A, 1, 0, 0); tk;
    chk("b2b.addb", W_ADD_B, 1, 0, 0); tk;
    chk("b2b.done", W_IDLE, 1, 1, 1); tk;
    chk("b2b.idle", W_IDLE, 0, 0, 1); tk;
    chk("b2b.clr2", W_CLR, 1, 0, 0);
    start = 1'b0; tk;
    chk("b2b.acca2", W_ACC_A, 1, 0, 0); tk; tk;
    chk("b2b.done2", W_IDLE, 1, 1, 1);
    ck("b2b.S", S, 16'd8);
`ifdef BLOCO_CONTROLE_BUSY_ERR_EN
    ck("b2b.err", {15'd0, err0}, 16'd0);
`endif
    tk;
    chk("b2b.idle2", W_IDLE, 0, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
